// File: rtl/id_stage.sv
// Decode stage: decodes the MIPS subset, resolves branches and jumps,
// detects operand hazards and registers the ID_EX bundle for EX.
module id_stage #(
    parameter int LOAD_BR_STALL = 2,
    parameter int ALU_BR_STALL  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [63:0]  IF_ID,
    input  logic [1:0]   status,
    input  logic [31:0]  rs_data,
    input  logic [31:0]  rt_data,
    output logic [4:0]   rs_addr,
    output logic [4:0]   rt_addr,
    output logic [31:0]  branch_target,
    output logic [31:0]  jump_target,
    output logic [31:0]  jr_target,
    output logic [2:0]   select_PC_next,
    output logic         PC_IF_ID_Write,
    output logic         undef_instr,
    output logic [152:0] ID_EX
);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_LUI = 4'd10;

    localparam logic [1:0] LD_LOAD  = 2'(LOAD_BR_STALL - 1);
    localparam logic [1:0] ALU_LOAD = 2'(ALU_BR_STALL - 1);
    localparam bit         ALU_STALL_EN = (ALU_BR_STALL != 0);

    logic [31:0] pc4;
    logic [31:0] instr;
    logic [5:0]  opc;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_ext;

    logic       undef;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_br;
    logic       br_eq;
    logic       is_jr;
    logic       is_j;
    logic       zext;
    logic       is_lui;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       link;
    logic [4:0] dest;

    logic [1:0] stall_cnt;
    logic [1:0] cnt_next;
    logic [4:0] mem_load_dest;

    logic       ex_mem_read;
    logic       ex_reg_write;
    logic [4:0] ex_dest;
    logic       br_jr;
    logic       dep_ex;
    logic       dep_mem;
    logic       haz_a;
    logic       haz_b_ld;
    logic       haz_b_alu;
    logic       haz_m;
    logic       quiet;
    logic       stall;
    logic       taken;
    logic       bubble;
    logic [152:0] id_ex_next;

    assign pc4      = IF_ID[63:32];
    assign instr    = IF_ID[31:0];
    assign opc      = instr[31:26];
    assign funct    = instr[5:0];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign imm      = instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_ext  = is_lui ? {imm, 16'h0000} :
                      zext   ? {16'h0000, imm} : imm_sext;

    // Instruction decode into control fields and operand usage.
    always_comb begin
        undef      = 1'b0;
        uses_rs    = 1'b0;
        uses_rt    = 1'b0;
        is_br      = 1'b0;
        br_eq      = 1'b0;
        is_jr      = 1'b0;
        is_j       = 1'b0;
        zext       = 1'b0;
        is_lui     = 1'b0;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_wr     = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        dest       = rt;
        unique case (1'b1)
            (opc == OP_R): begin
                dest    = rd;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                reg_wr  = 1'b1;
                unique case (1'b1)
                    (funct == F_ADD), (funct == F_ADDU): alu_op = ALU_ADD;
                    (funct == F_SUB), (funct == F_SUBU): alu_op = ALU_SUB;
                    (funct == F_AND): alu_op = ALU_AND;
                    (funct == F_OR):  alu_op = ALU_OR;
                    (funct == F_XOR): alu_op = ALU_XOR;
                    (funct == F_NOR): alu_op = ALU_NOR;
                    (funct == F_SLT): alu_op = ALU_SLT;
                    (funct == F_SLL): begin
                        alu_op  = ALU_SLL;
                        uses_rs = 1'b0;
                    end
                    (funct == F_SRL): begin
                        alu_op  = ALU_SRL;
                        uses_rs = 1'b0;
                    end
                    (funct == F_SRA): begin
                        alu_op  = ALU_SRA;
                        uses_rs = 1'b0;
                    end
                    (funct == F_JR): begin
                        is_jr   = 1'b1;
                        uses_rt = 1'b0;
                        reg_wr  = 1'b0;
                    end
                    (funct == F_JALR): begin
                        is_jr   = 1'b1;
                        uses_rt = 1'b0;
                        link    = 1'b1;
                    end
                    default: begin
                        undef   = 1'b1;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                        reg_wr  = 1'b0;
                    end
                endcase
            end
            (opc == OP_LW): begin
                uses_rs    = 1'b1;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            (opc == OP_SW): begin
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            (opc == OP_ADDI), (opc == OP_ADDIU): begin
                uses_rs = 1'b1;
                alu_src = 1'b1;
                reg_wr  = 1'b1;
            end
            (opc == OP_ANDI): begin
                uses_rs = 1'b1;
                alu_src = 1'b1;
                reg_wr  = 1'b1;
                zext    = 1'b1;
                alu_op  = ALU_AND;
            end
            (opc == OP_ORI): begin
                uses_rs = 1'b1;
                alu_src = 1'b1;
                reg_wr  = 1'b1;
                zext    = 1'b1;
                alu_op  = ALU_OR;
            end
            (opc == OP_SLTI): begin
                uses_rs = 1'b1;
                alu_src = 1'b1;
                reg_wr  = 1'b1;
                alu_op  = ALU_SLT;
            end
            (opc == OP_LUI): begin
                alu_src = 1'b1;
                reg_wr  = 1'b1;
                is_lui  = 1'b1;
                alu_op  = ALU_LUI;
            end
            (opc == OP_BEQ): begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_br   = 1'b1;
                br_eq   = 1'b1;
                alu_op  = ALU_SUB;
            end
            (opc == OP_BNE): begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_br   = 1'b1;
                alu_op  = ALU_SUB;
            end
            (opc == OP_J): is_j = 1'b1;
            (opc == OP_JAL): begin
                is_j   = 1'b1;
                link   = 1'b1;
                reg_wr = 1'b1;
                dest   = 5'd31;
            end
            default: undef = 1'b1;
        endcase
    end

    assign ex_mem_read  = ID_EX[4];
    assign ex_reg_write = ID_EX[2];
    assign ex_dest      = ID_EX[14:10];
    assign br_jr        = is_br | is_jr;

    assign dep_ex  = (ex_dest != 5'd0) &&
                     ((uses_rs && rs == ex_dest) ||
                      (uses_rt && rt == ex_dest));
    assign dep_mem = (mem_load_dest != 5'd0) &&
                     ((uses_rs && rs == mem_load_dest) ||
                      (uses_rt && rt == mem_load_dest));

    assign haz_a     = !br_jr && ex_mem_read && dep_ex;
    assign haz_b_ld  = br_jr && ex_reg_write && ex_mem_read && dep_ex;
    assign haz_b_alu = br_jr && ex_reg_write && !ex_mem_read &&
                       dep_ex && ALU_STALL_EN;
    assign haz_m     = br_jr && dep_mem && (stall_cnt != 2'd0);

    assign quiet = (status == 2'b00);
    assign stall = quiet && ((stall_cnt != 2'd0) ||
                   haz_a || haz_b_ld || haz_b_alu || haz_m);
    assign taken = is_br && (br_eq ? (rs_data == rt_data)
                                   : (rs_data != rt_data));

    assign rs_addr        = rs;
    assign rt_addr        = rt;
    assign branch_target  = pc4 + {imm_sext[29:0], 2'b00};
    assign jump_target    = {pc4[31:28], instr[25:0], 2'b00};
    assign jr_target      = rs_data;
    assign undef_instr    = undef;
    assign PC_IF_ID_Write = !stall;
    assign select_PC_next = (!quiet || stall) ? 3'b000
                                              : {taken, is_j, is_jr};

    assign bubble = !quiet || stall || undef || (instr == 32'h0);

    // Next stall count: a running count only winds down, never reloads.
    always_comb begin
        cnt_next = 2'd0;
        if (!quiet)
            cnt_next = 2'd0;
        else if (stall_cnt != 2'd0)
            cnt_next = stall_cnt - 2'd1;
        else if (haz_b_ld)
            cnt_next = LD_LOAD;
        else if (haz_b_alu)
            cnt_next = ALU_LOAD;
    end

    // Pack the ID_EX bundle, or a bubble.
    always_comb begin
        id_ex_next = '0;
        if (!bubble)
            id_ex_next = {pc4, rs_data, rt_data, imm_ext, rs, rt, dest,
                          alu_op, alu_src, mem_read, mem_write,
                          reg_wr && (dest != 5'd0), mem_to_reg, link};
    end

    // Pipeline register, stall counter and MEM-stage load tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX         <= '0;
            stall_cnt     <= 2'd0;
            mem_load_dest <= 5'd0;
        end else begin
            ID_EX         <= id_ex_next;
            stall_cnt     <= cnt_next;
            mem_load_dest <= ex_mem_read ? ex_dest : 5'd0;
        end
    end

endmodule
